wb_commit: RTL

//  Writeback stage feeding the register-file write port (reg_write/write_reg/write_data).

---
 rtl/wb_pkg.sv | 36 +++
 rtl/wb_ldq.sv | 64 ++++++
 rtl/wb_commit.sv | 112 +++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Writeback shared types: load funct3 codes, AXI response code, load-queue entry and alignment helper.
// Pure declarations; no timing or flow control of its own.
package wb_pkg;

  localparam logic [2:0] LB_F3  = 3'b000;
  localparam logic [2:0] LH_F3  = 3'b001;
  localparam logic [2:0] LW_F3  = 3'b010;
  localparam logic [2:0] LBU_F3 = 3'b100;
  localparam logic [2:0] LHU_F3 = 3'b101;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef struct packed {
    logic [4:0] rd;
    logic [2:0] funct3;
    logic [1:0] off;
  } ldq_entry_t;

  function automatic logic [31:0] align_load(input logic [2:0]  funct3,
                                             input logic [1:0]  off,
                                             input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    b = rdata[{off, 3'b000} +: 8];
    h = off[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      LB_F3:   align_load = {{24{b[7]}}, b};
      LBU_F3:  align_load = {24'd0, b};
      LH_F3:   align_load = {{16{h[15]}}, h};
      LHU_F3:  align_load = {16'd0, h};
      LW_F3:   align_load = rdata;
      default: align_load = rdata;
    endcase
  endfunction

endpackage

// File: rtl/wb_ldq.sv
// In-order outstanding-load FIFO; push/pop take effect at the clock edge, head/full/empty are combinational.
// Push is dropped when full (even with a same-cycle pop); pop is dropped when empty.
module wb_ldq
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  ldq_entry_t            push_entry,
  input  logic                  pop,
  output logic                  full,
  output logic                  empty,
  output ldq_entry_t            head,
  output logic [DEPTH-1:0]      entry_vld,
  output logic [DEPTH-1:0][4:0] entry_rd
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  ldq_entry_t      mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // A slot is live when its distance from the read pointer is below the occupancy.
  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    logic [PW-1:0] rel;
    assign rel          = PW'(i) - rd_ptr;
    assign entry_vld[i] = ({1'b0, rel} < count);
    assign entry_rd[i]  = mem[i].rd;
  end

endmodule

// File: rtl/wb_commit.sv
// Writeback merge of ALU results and AXI load returns into one registered regfile write (1-cycle latency).
// Load returns win over the ALU; issue stalls when the load queue is full. Optional LD_RESP_ERR_EN: error responses.
module wb_commit
  import wb_pkg::*;
#(
  parameter int LDQ_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        ld_issue_valid,
  output logic        ld_issue_ready,
  input  logic [4:0]  ld_issue_rd,
  input  logic [2:0]  ld_issue_funct3,
  input  logic [1:0]  ld_issue_off,
  input  logic        rvalid,
  output logic        rready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  output logic        reg_write,
  output logic [4:0]  write_reg,
  output logic [31:0] write_data,
  output logic [31:0] rd_pending,
  output logic        ld_err,
  output logic [4:0]  ld_err_rd
);

  logic                      ldq_full;
  logic                      ldq_empty;
  ldq_entry_t                ldq_head;
  ldq_entry_t                ldq_push_entry;
  logic [LDQ_DEPTH-1:0]      ldq_vld;
  logic [LDQ_DEPTH-1:0][4:0] ldq_rd;
  logic                      ld_pop;
  logic                      alu_acc;
  logic                      ld_bad;

  assign ldq_push_entry = '{rd: ld_issue_rd, funct3: ld_issue_funct3, off: ld_issue_off};

  wb_ldq #(.DEPTH(LDQ_DEPTH)) u_ldq (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (ld_issue_valid),
    .push_entry (ldq_push_entry),
    .pop        (ld_pop),
    .full       (ldq_full),
    .empty      (ldq_empty),
    .head       (ldq_head),
    .entry_vld  (ldq_vld),
    .entry_rd   (ldq_rd)
  );

  assign ld_issue_ready = ~ldq_full;
  assign rready         = ~ldq_empty;
  assign ld_pop         = rvalid & ~ldq_empty;
  assign alu_ready      = ~ld_pop;
  assign alu_acc        = alu_valid & alu_ready;

`ifdef LD_RESP_ERR_EN
  assign ld_bad = (rresp != RESP_OKAY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_err    <= 1'b0;
      ld_err_rd <= '0;
    end else begin
      ld_err <= ld_pop & ld_bad;
      if (ld_pop & ld_bad) ld_err_rd <= ldq_head.rd;
    end
  end
`else
  logic unused_rresp;
  assign unused_rresp = ^rresp;
  assign ld_bad       = 1'b0;
  assign ld_err       = 1'b0;
  assign ld_err_rd    = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_write  <= 1'b0;
      write_reg  <= '0;
      write_data <= '0;
    end else begin
      reg_write <= 1'b0;
      if (ld_pop) begin
        if (!ld_bad) begin
          reg_write  <= (ldq_head.rd != 5'd0);
          write_reg  <= ldq_head.rd;
          write_data <= align_load(ldq_head.funct3, ldq_head.off, rdata);
        end
      end else if (alu_acc) begin
        reg_write  <= (alu_rd != 5'd0);
        write_reg  <= alu_rd;
        write_data <= alu_data;
      end
    end
  end

  // Pending bit drops as the entry pops; the registered write follows one cycle later.
  always_comb begin
    rd_pending = '0;
    for (int i = 0; i < LDQ_DEPTH; i++) begin
      if (ldq_vld[i]) rd_pending[ldq_rd[i]] = 1'b1;
    end
    rd_pending[0] = 1'b0;
  end

endmodule
